// File: rtl/if_fetch_buf_pkg.sv
// rtl/if_fetch_buf_pkg.sv - shared bus widths and reset fetch address for the fetch buffer
// Provides the default instruction/address widths and RESET_PC used by if_fetch_buf.
package if_fetch_buf_pkg;

    localparam int IFB_ADDR_W = 32;
    localparam int IFB_INST_W = 32;
    localparam logic [IFB_ADDR_W-1:0] IFB_RESET_PC = '0;

endpackage

// File: rtl/if_fetch_buf_fifo_sync.sv
// rtl/if_fetch_buf_fifo_sync.sv - flop-based synchronous FIFO holding fetched entries
// Ports: clk, rst (sync, active high), flush_i (drop all entries),
//        push_i/push_data_i (write at tail), pop_i (advance head),
//        count_o (occupancy 0..DEPTH), head_o (head entry, zero when empty).
module fifo_sync #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [WIDTH-1:0]         head_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data entries carry no reset; stale contents are masked by the head zeroing.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign count_o = count_q;
    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/if_fetch_buf.sv
// rtl/if_fetch_buf.sv - instruction fetch PC generator with decoupling fetch queue
// Ports: clk, rst (sync, active high); ROM side rom_ce_o/rom_addr_o/rom_data_i
//        (combinational ROM); redirect_i/redirect_pc_i (flush and retarget);
//        decode side id_valid_o/id_ready_i/id_pc_o/id_inst_o; count_o occupancy.
module if_fetch_buf
    import if_fetch_buf_pkg::*;
#(
    parameter int                ADDR_W   = IFB_ADDR_W,
    parameter int                INST_W   = IFB_INST_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFB_RESET_PC),
    parameter int                PC_STEP  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INST_W-1:0]        rom_data_i,
    output logic                     rom_ce_o,
    output logic [ADDR_W-1:0]        rom_addr_o,
    input  logic                     redirect_i,
    input  logic [ADDR_W-1:0]        redirect_pc_i,
    input  logic                     id_ready_i,
    output logic                     id_valid_o,
    output logic [ADDR_W-1:0]        id_pc_o,
    output logic [INST_W-1:0]        id_inst_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic              rom_ce_q;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              push, pop;
    logic [CW-1:0]     count;
    logic [ADDR_W+INST_W-1:0] head;

    assign pop  = id_valid_o && id_ready_i;
    // A full queue still accepts a fetch when the head leaves in the same cycle.
    assign push = rom_ce_q && !redirect_i && ((count < CW'(DEPTH)) || pop);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_i)  fetch_pc_d = redirect_pc_i;
        else if (push)   fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
    end

    always_ff @(posedge clk) begin
        rom_ce_q <= ~rst;
        if (rst) fetch_pc_q <= RESET_PC;
        else     fetch_pc_q <= fetch_pc_d;
    end

    fifo_sync #(
        .WIDTH (ADDR_W + INST_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_i),
        .push_i      (push),
        .push_data_i ({fetch_pc_q, rom_data_i}),
        .pop_i       (pop),
        .count_o     (count),
        .head_o      (head)
    );

    assign rom_ce_o              = rom_ce_q;
    assign rom_addr_o            = fetch_pc_q;
    assign count_o               = count;
    assign id_valid_o            = (count != '0);
    assign {id_pc_o, id_inst_o}  = head;

endmodule

// File: tb/tb_if_fetch_buf.sv
// tb/tb_if_fetch_buf.sv - self-checking bench for if_fetch_buf
module tb_if_fetch_buf;

    logic        clk;
    logic        rst;
    logic [31:0] rom_data_i;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_ready_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic [2:0]  count_o;

    localparam logic [31:0] XOR_K = 32'hA5A50000;

    if_fetch_buf #(
        .ADDR_W   (32),
        .INST_W   (32),
        .DEPTH    (4),
        .RESET_PC (32'h0),
        .PC_STEP  (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rom_data_i    (rom_data_i),
        .rom_ce_o      (rom_ce_o),
        .rom_addr_o    (rom_addr_o),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .id_ready_i    (id_ready_i),
        .id_valid_o    (id_valid_o),
        .id_pc_o       (id_pc_o),
        .id_inst_o     (id_inst_o),
        .count_o       (count_o)
    );

    assign rom_data_i = rom_addr_o ^ XOR_K;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        ce;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] idpc;
        int          cnt;
    } vec_t;

    int          checks;
    int          failures;
    logic        known;
    logic        model_ce;
    logic [31:0] model_pc;
    ent_t        exp_q[$];
    logic [31:0] acc_q[$];
    vec_t        vt[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance the model.
    task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
        logic m_pop;
        logic m_push;
        ent_t e;
        rst           = r;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        id_ready_i    = rdy;
        #1;
        m_pop  = 1'b0;
        m_push = 1'b0;
        if (known) begin
            check("sb_ce",    64'(rom_ce_o),   64'(model_ce));
            check("sb_addr",  64'(rom_addr_o), 64'(model_pc));
            check("sb_count", 64'(count_o),    64'(exp_q.size()));
            check("sb_valid", 64'(id_valid_o), 64'(exp_q.size() != 0));
            if (exp_q.size() == 0) begin
                check("sb_empty_pc",   64'(id_pc_o),   64'h0);
                check("sb_empty_inst", 64'(id_inst_o), 64'h0);
            end
            m_pop  = !r && !rd && (exp_q.size() != 0) && rdy;
            m_push = !r && model_ce && !rd && ((exp_q.size() < 4) || m_pop);
            if (m_pop) begin
                e = exp_q.pop_front();
                check("sb_head_pc",   64'(id_pc_o),   64'(e.pc));
                check("sb_head_inst", 64'(id_inst_o), 64'(e.inst));
                acc_q.push_back(id_pc_o);
            end
        end
        @(posedge clk);
        if (r) begin
            model_ce = 1'b0;
            model_pc = 32'h0;
            exp_q.delete();
            known    = 1'b1;
        end else begin
            model_ce = 1'b1;
            if (rd) begin
                exp_q.delete();
                model_pc = rpc;
            end else if (m_push) begin
                e.pc   = model_pc;
                e.inst = model_pc ^ XOR_K;
                exp_q.push_back(e);
                model_pc = model_pc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        known         = 1'b0;
        model_ce      = 1'b0;
        model_pc      = 32'h0;
        rst           = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        id_ready_i    = 1'b0;

        // Fill to full with decode stalled, then one pop+push while full.
        vt[0] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h0, 0};
        vt[1] = '{1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0, 0};
        vt[2] = '{1'b0, 1'b0, 1'b1, 32'h04, 1'b1, 32'h0, 1};
        vt[3] = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h0, 2};
        vt[4] = '{1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h0, 3};
        vt[5] = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h0, 4};
        vt[6] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0, 4};
        vt[7] = '{1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 32'h4, 4};

        @(negedge clk);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            check($sformatf("vec%0d_ce", i),    64'(rom_ce_o),   64'(vt[i].ce));
            check($sformatf("vec%0d_addr", i),  64'(rom_addr_o), 64'(vt[i].addr));
            check($sformatf("vec%0d_valid", i), 64'(id_valid_o), 64'(vt[i].valid));
            check($sformatf("vec%0d_idpc", i),  64'(id_pc_o),    64'(vt[i].idpc));
            check($sformatf("vec%0d_count", i), 64'(count_o),    64'(vt[i].cnt));
            step(vt[i].rst, 1'b0, 32'h0, vt[i].rdy);
        end

        // Streaming from reset with decode always ready: one-cycle latency.
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("rst_ce", 64'(rom_ce_o), 64'h0);
        check("rst_valid", 64'(id_valid_o), 64'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("lat_c1_ce", 64'(rom_ce_o), 64'h1);
        check("lat_c1_addr", 64'(rom_addr_o), 64'h0);
        check("lat_c1_valid", 64'(id_valid_o), 64'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("lat_c2_addr", 64'(rom_addr_o), 64'h4);
        check("lat_c2_valid", 64'(id_valid_o), 64'h1);
        check("lat_c2_pc", 64'(id_pc_o), 64'h0);
        check("lat_c2_inst", 64'(id_inst_o), 64'hA5A50000);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("lat_c3_addr", 64'(rom_addr_o), 64'h8);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect with three entries queued.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        check("redir_pre_count", 64'(count_o), 64'd3);
        step(1'b0, 1'b1, 32'h100, 1'b0);
        check("redir_count", 64'(count_o), 64'd0);
        check("redir_valid", 64'(id_valid_o), 64'h0);
        check("redir_addr", 64'(rom_addr_o), 64'h100);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check("redir_head_pc", 64'(id_pc_o), 64'h100);
        check("redir_head_inst", 64'(id_inst_o), 64'(32'h100 ^ XOR_K));

        // Mid-operation reset with two entries queued.
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check("mrst_pre_count", 64'(count_o), 64'd2);
        step(1'b1, 1'b1, 32'h200, 1'b0);
        check("mrst_count", 64'(count_o), 64'd0);
        check("mrst_ce", 64'(rom_ce_o), 64'h0);
        check("mrst_addr", 64'(rom_addr_o), 64'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check("mrst_resume_addr", 64'(rom_addr_o), 64'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check("mrst_resume_pc", 64'(id_pc_o), 64'h0);

        // Fetch address wraps past the top of the address space.
        step(1'b0, 1'b1, 32'hFFFFFFFC, 1'b0);
        check("wrap_addr0", 64'(rom_addr_o), 64'hFFFFFFFC);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check("wrap_addr1", 64'(rom_addr_o), 64'h0);
        check("wrap_head", 64'(id_pc_o), 64'hFFFFFFFC);

        // Alternating decode ready across pointer wrap; accepted PCs must be contiguous.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        acc_q.delete();
        for (int i = 0; i < 22; i++) step(1'b0, 1'b0, 32'h0, (i % 2) == 0);
        check("alt_accept_n", 64'(acc_q.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < acc_q.size())
                check($sformatf("alt_accept%0d", i), 64'(acc_q[i]), 64'(32'(i * 4)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
